// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, miss-FSM state encoding and line alignment helper
package dcache_pkg;
  localparam int LINE_W   = 128;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 4;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WB_REQ  = 3'd1;
  localparam state_t S_WB_HOLD = 3'd2;
  localparam state_t S_RD_REQ  = 3'd3;
  localparam state_t S_RD_WAIT = 3'd4;
  localparam state_t S_DONE    = 3'd5;
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~{{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};
  endfunction
endpackage

// File: rtl/miss_watchdog.sv
// miss_watchdog: counts cycles spent in one wait state, expires after TIMEOUT of them
module miss_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));
  // restart on every state change, saturate at the expiry point
  always_comb cnt_d = clear_i ? '0 : (enable_i && !expire_o) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/dcache_miss_unit.sv
// dcache_miss_unit: one-at-a-time miss handler doing victim writeback then line refill
module dcache_miss_unit
  import dcache_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_rdy,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [LINE_W-1:0] victim_data,
  output logic              refill_valid,
  output logic [ADDR_W-1:0] refill_addr,
  output logic [LINE_W-1:0] refill_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic [LINE_W-1:0] ret_data,
  output logic              busy,
  output logic              timeout_err
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [LINE_W-1:0] wr_data_q, refill_data_q;
  logic timeout_q, timeout_hit, wd_expire, accept, capture;
  assign accept  = miss_valid && miss_rdy;
  assign capture = ret_valid && (state_q == S_RD_REQ || state_q == S_RD_WAIT);
  miss_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_d != state_q),
    .enable_i (state_q == S_WB_REQ || state_q == S_RD_REQ || state_q == S_RD_WAIT),
    .expire_o (wd_expire)
  );
  // state register
  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
  // next state; a returned line in RD_REQ wins over rd_rdy, both win over the watchdog
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE:    state_d = accept ? (miss_dirty ? S_WB_REQ : S_RD_REQ) : S_IDLE;
      S_WB_REQ:  begin
        state_d     = wr_rdy ? S_WB_HOLD : wd_expire ? S_IDLE : S_WB_REQ;
        timeout_hit = !wr_rdy && wd_expire;
      end
      S_WB_HOLD: state_d = S_RD_REQ;
      S_RD_REQ:  begin
        state_d     = ret_valid ? S_DONE : rd_rdy ? S_RD_WAIT : wd_expire ? S_IDLE : S_RD_REQ;
        timeout_hit = !ret_valid && !rd_rdy && wd_expire;
      end
      S_RD_WAIT: begin
        state_d     = ret_valid ? S_DONE : wd_expire ? S_IDLE : S_RD_WAIT;
        timeout_hit = !ret_valid && wd_expire;
      end
      default:   state_d = S_IDLE;
    endcase
  end
  // outputs decoded from the current state
  always_comb begin
    miss_rdy     = (state_q == S_IDLE) && !rst;
    busy         = state_q != S_IDLE;
    wr_req       = state_q == S_WB_REQ;
    rd_req       = state_q == S_RD_REQ;
    refill_valid = state_q == S_DONE;
  end
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_addr     = rd_addr_q;
  assign refill_addr = rd_addr_q;
  assign refill_data = refill_data_q;
  assign timeout_err = timeout_q;
  // datapath: writeback regs only move on a dirty accept so memory sees stable data afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_addr_q     <= '0;
      refill_data_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      if (accept && miss_dirty) wr_addr_q <= line_align(victim_addr);
      if (accept && miss_dirty) wr_data_q <= victim_data;
      if (accept) rd_addr_q <= line_align(miss_addr);
      if (capture) refill_data_q <= ret_data;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dcache_miss_unit.sv
// tb_dcache_miss_unit: directed plus randomized miss transactions against a transaction-level model
module tb_dcache_miss_unit;
  import dcache_pkg::*;
  logic clk = 0, rst = 1;
  logic miss_valid = 0, miss_dirty = 0, wr_rdy = 0, rd_rdy = 0, ret_valid = 0;
  logic [ADDR_W-1:0] miss_addr = '0, victim_addr = '0;
  logic [LINE_W-1:0] victim_data = '0, ret_data = '0;
  logic miss_rdy, refill_valid, wr_req, rd_req, busy, timeout_err;
  logic [ADDR_W-1:0] refill_addr, wr_addr, rd_addr;
  logic [LINE_W-1:0] refill_data, wr_data;
  int ntests = 0, nfail = 0, npulse = 0, exp_pulse = 0;

  dcache_miss_unit #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_rdy(miss_rdy), .miss_addr(miss_addr),
    .miss_dirty(miss_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_data(refill_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
    .ret_data(ret_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (refill_valid) npulse++;

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full transaction; memory answers after the given delays, expectations come from the protocol rules
  task automatic run_miss(input logic [31:0] a, input bit d, input logic [31:0] va, input logic [127:0] vd,
                          input logic [127:0] rdat, input int kwr, input int krd, input int kret,
                          input bit fast, input bit keep, input logic [31:0] nxt);
    chk("miss_rdy_idle", 128'(miss_rdy), 1);
    miss_valid = 1; miss_addr = a; miss_dirty = d; victim_addr = va; victim_data = vd;
    step();
    miss_valid = keep; miss_addr = keep ? nxt : $urandom; miss_dirty = 1'($urandom);
    victim_addr = $urandom; victim_data = rnd128();
    chk("busy", 128'(busy), 1);
    chk("miss_rdy_busy", 128'(miss_rdy), 0);
    if (d) begin
      for (int i = 0; i <= kwr; i++) begin
        chk("wr_req", 128'(wr_req), 1);
        chk("wr_addr", 128'(wr_addr), 128'(al(va)));
        chk("wr_data", wr_data, vd);
        chk("rd_req_in_wb", 128'(rd_req), 0);
        wr_rdy = (i == kwr);
        step();
      end
      wr_rdy = 0;
      chk("wr_req_drop", 128'(wr_req), 0);
      chk("wr_data_hold", wr_data, vd);
      chk("wr_addr_hold", 128'(wr_addr), 128'(al(va)));
      chk("rd_req_in_hold", 128'(rd_req), 0);
      step();
    end else chk("no_wr_req", 128'(wr_req), 0);
    for (int i = 0; i <= krd; i++) begin
      chk("rd_req", 128'(rd_req), 1);
      chk("rd_addr", 128'(rd_addr), 128'(al(a)));
      chk("refill_early", 128'(refill_valid), 0);
      if (fast && i == krd) begin
        ret_valid = 1; ret_data = rdat;
      end else rd_rdy = (i == krd);
      step();
    end
    rd_rdy = 0; ret_valid = 0;
    if (!fast) begin
      for (int i = 0; i <= kret; i++) begin
        chk("rd_req_drop", 128'(rd_req), 0);
        chk("refill_wait", 128'(refill_valid), 0);
        ret_valid = (i == kret); ret_data = rdat;
        step();
      end
      ret_valid = 0;
    end
    ret_data = rnd128();
    exp_pulse++;
    chk("refill_valid", 128'(refill_valid), 1);
    chk("refill_addr", 128'(refill_addr), 128'(al(a)));
    chk("refill_data", refill_data, rdat);
    step();
    chk("refill_pulse_end", 128'(refill_valid), 0);
    chk("back_idle", 128'(busy), 0);
    chk("refill_data_held", refill_data, rdat);
    chk("pulse_count", 128'(npulse), 128'(exp_pulse));
  endtask

  initial begin
    int n;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    step(); step();
    chk("rst_miss_rdy", 128'(miss_rdy), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_wr_req", 128'(wr_req), 0);
    chk("rst_rd_req", 128'(rd_req), 0);
    chk("rst_refill_valid", 128'(refill_valid), 0);
    chk("rst_timeout", 128'(timeout_err), 0);
    chk("rst_refill_data", refill_data, 0);
    rst = 0;
    #1;
    chk("miss_rdy_after_rst", 128'(miss_rdy), 1);
    // clean miss, dirty miss, slow memory
    run_miss(32'h0000_1234, 0, 32'h0, 128'h0, a5, 0, 0, 0, 0, 0, 0);
    run_miss(32'h0000_3458, 1, 32'h0000_2000, {4{32'h1111_1111}}, rnd128(), 0, 0, 0, 0, 0, 0);
    run_miss(32'h0000_5abc, 1, 32'h0000_6ff0, rnd128(), rnd128(), 9, 2, 5, 0, 0, 0);
    // read never accepted: watchdog aborts
    miss_valid = 1; miss_addr = 32'h0000_7770; miss_dirty = 0;
    step();
    miss_valid = 0;
    n = 0;
    while (rd_req && n < 100) begin n++; step(); end
    chk("rd_timeout_cycles", 128'(n), 64);
    chk("timeout_err_set", 128'(timeout_err), 1);
    chk("timeout_idle", 128'(miss_rdy), 1);
    chk("timeout_no_refill", 128'(npulse), 128'(exp_pulse));
    // writeback never accepted: watchdog aborts too, flag stays set
    miss_valid = 1; miss_addr = 32'h0000_8880; miss_dirty = 1; victim_addr = 32'h0000_9990;
    step();
    miss_valid = 0;
    n = 0;
    while (wr_req && n < 100) begin n++; step(); end
    chk("wr_timeout_cycles", 128'(n), 64);
    chk("wr_timeout_rd_req", 128'(rd_req), 0);
    chk("timeout_sticky", 128'(timeout_err), 1);
    run_miss(32'h0000_abcd, 0, 32'h0, 128'h0, rnd128(), 0, 1, 1, 0, 0, 0);
    chk("timeout_still_sticky", 128'(timeout_err), 1);
    // reset while waiting for the returned line
    miss_valid = 1; miss_addr = 32'h0000_c0de; miss_dirty = 0;
    step();
    miss_valid = 0; rd_rdy = 1;
    step();
    rd_rdy = 0;
    chk("in_rd_wait", 128'(busy), 1);
    rst = 1;
    step();
    chk("rstmid_busy", 128'(busy), 0);
    chk("rstmid_miss_rdy", 128'(miss_rdy), 0);
    chk("rstmid_timeout", 128'(timeout_err), 0);
    chk("rstmid_refill_data", refill_data, 0);
    chk("rstmid_wr_addr", 128'(wr_addr), 0);
    chk("rstmid_wr_data", wr_data, 0);
    chk("rstmid_rd_addr", 128'(rd_addr), 0);
    rst = 0;
    #1;
    chk("rstmid_miss_rdy_after", 128'(miss_rdy), 1);
    ret_valid = 1; rd_rdy = 1; wr_rdy = 1; ret_data = rnd128();
    step();
    ret_valid = 0; rd_rdy = 0; wr_rdy = 0;
    chk("stray_busy", 128'(busy), 0);
    chk("stray_refill_data", refill_data, 0);
    chk("stray_pulse", 128'(npulse), 128'(exp_pulse));
    run_miss(32'h0001_0004, 1, 32'h0002_0008, rnd128(), rnd128(), 1, 0, 2, 0, 0, 0);
    // back-to-back clean misses with miss_valid held through the first
    run_miss(32'h0003_0011, 0, 32'h0, 128'h0, rnd128(), 0, 0, 0, 1, 1, 32'h0004_0022);
    run_miss(32'h0004_0022, 0, 32'h0, 128'h0, rnd128(), 0, 0, 0, 1, 0, 0);
    // randomized transactions
    for (int t = 0; t < 20; t++)
      run_miss($urandom, 1'($urandom), $urandom, rnd128(), rnd128(), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom), 0, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
